sram_rw: RTL and testbench

- Parametrised single-port synchronous SRAM. Successor to the read-only `sram` block.
- Adds a write path and a configurable read latency (1 or 2 cycles) with a `data_valid` strobe.
- Adds a hardware clear engine that fills memory with a constant after reset or on request.
- Sits between the CPU datapath and the register/instruction store. `ready` gates all accesses.

---
 rtl/sram_rw.sv | 138 +++++++++++++
 tb/tb_sram_rw.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rw.sv
// sram_rw: single-port synchronous SRAM with write path, clear engine and
// a 1- or 2-cycle pipelined read path.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   cs, we     chip select / write enable; an access is taken when ready=1
//   address    word address
//   data_in    write data
//   clear      request a full memory re-clear (sampled only in READY)
//   ready      1 while accesses are accepted
//   data_out   read data, holds its value between reads
//   data_valid one-cycle strobe marking new read data
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | clear engine writes clr_val to mem[ptr] each edge
// ST_READY | normal read/write accesses accepted
module sram_rw #(
    parameter int               addr    = 4,
    parameter int               width   = 8,
    parameter int               length  = 16,
    parameter int               rd_lat  = 1,
    parameter logic [width-1:0] clr_val = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             we,
    input  logic [addr-1:0]  address,
    input  logic [width-1:0] data_in,
    input  logic             clear,
    output logic             ready,
    output logic [width-1:0] data_out,
    output logic             data_valid
);

    generate
        if (rd_lat != 1 && rd_lat != 2) begin : g_bad_rd_lat
            $error("sram_rw: rd_lat must be 1 or 2");
        end
        if (length < 2 || length > (1 << addr)) begin : g_bad_length
            $error("sram_rw: length must satisfy 2 <= length <= 2**addr");
        end
    endgenerate

    localparam logic [addr:0]   len_c  = (addr + 1)'(length);
    localparam logic [addr-1:0] last_c = addr'(length - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t           state;
    logic [addr-1:0]  ptr;
    logic [width-1:0] mem [0:length-1];

    logic             addr_ok;
    logic             acc;
    logic             rd_acc;
    logic [width-1:0] rd_word;
    logic             mem_we;
    logic [addr-1:0]  mem_wa;
    logic [width-1:0] mem_wd;

    // second read stage, only meaningful when rd_lat == 2
    logic             s1_valid;
    logic [width-1:0] s1_data;

    assign addr_ok = ({1'b0, address} < len_c);
    assign acc     = (state == ST_READY) && cs;
    assign rd_acc  = acc && !we;
    // out-of-range reads return the clear value instead of touching the array
    assign rd_word = addr_ok ? mem[address] : clr_val;

    always_comb begin
        mem_we = 1'b0;
        mem_wa = ptr;
        mem_wd = clr_val;
        if (state == ST_CLEAR) begin
            mem_we = 1'b1;
        end else if (acc && we && addr_ok) begin
            mem_we = 1'b1;
            mem_wa = address;
            mem_wd = data_in;
        end
    end

    // memory contents survive reset; writes are suppressed while rst is held
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_CLEAR;
            ptr        <= '0;
            ready      <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            s1_valid   <= 1'b0;
            s1_data    <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (ptr == last_c) begin
                        ptr   <= '0;
                        state <= ST_READY;
                        ready <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                ST_READY: begin
                    // an access on the same edge as clear is still taken
                    if (clear) begin
                        state <= ST_CLEAR;
                        ready <= 1'b0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase

            // read data is captured at acceptance, so later clear-engine
            // writes cannot disturb reads already in flight
            if (rd_lat == 1) begin
                data_valid <= rd_acc;
                if (rd_acc) data_out <= rd_word;
            end else begin
                s1_valid   <= rd_acc;
                if (rd_acc) s1_data <= rd_word;
                data_valid <= s1_valid;
                if (s1_valid) data_out <= s1_data;
            end
        end
    end

endmodule

// File: tb/tb_sram_rw.sv
module tb_sram_rw;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic [3:0] address = '0;
    logic [7:0] data_in = '0;
    logic       clear = 1'b0;

    logic [1:0] rdy;
    logic [1:0] dv;
    logic [7:0] dout [2];

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // instance 0: length 16, rd_lat 1, clr_val 00
    sram_rw u_a (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .address(address),
        .data_in(data_in), .clear(clear), .ready(rdy[0]),
        .data_out(dout[0]), .data_valid(dv[0])
    );

    // instance 1: length 12, rd_lat 2, clr_val 3C
    sram_rw #(.addr(4), .width(8), .length(12), .rd_lat(2), .clr_val(8'h3C)) u_b (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .address(address),
        .data_in(data_in), .clear(clear), .ready(rdy[1]),
        .data_out(dout[1]), .data_valid(dv[1])
    );

    function automatic int len_of(input int k);
        return (k == 0) ? 16 : 12;
    endfunction
    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction
    function automatic logic [7:0] clr_of(input int k);
        return (k == 0) ? 8'h00 : 8'h3C;
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem  [2][16];
    int         clr_left [2];
    bit         m_rdy  [2];
    bit         m_dv   [2];
    logic [7:0] m_dout [2];
    bit         prev_v [2];
    logic [7:0] prev_d [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            clr_left[k] = len_of(k);
            m_rdy[k]    = 1'b0;
            m_dv[k]     = 1'b0;
            m_dout[k]   = 8'h00;
            prev_v[k]   = 1'b0;
            prev_d[k]   = 8'h00;
        end
    endtask

    task automatic model_step(input int k);
        bit         rv;
        logic [7:0] rd;
        int         a;
        rv = 1'b0;
        rd = 8'h00;
        a  = int'(address);
        if (clr_left[k] > 0) begin
            m_mem[k][len_of(k) - clr_left[k]] = clr_of(k);
            clr_left[k]--;
            m_rdy[k] = (clr_left[k] == 0);
        end else begin
            if (cs && !we) begin
                rv = 1'b1;
                rd = (a < len_of(k)) ? m_mem[k][a] : clr_of(k);
            end
            if (cs && we && a < len_of(k)) m_mem[k][a] = data_in;
            if (clear) begin
                clr_left[k] = len_of(k);
                m_rdy[k]    = 1'b0;
            end
        end
        // a read shows up lat-1 edges after the edge that accepted it
        if (lat_of(k) == 1) begin
            m_dv[k] = rv;
            if (rv) m_dout[k] = rd;
        end else begin
            m_dv[k] = prev_v[k];
            if (prev_v[k]) m_dout[k] = prev_d[k];
            prev_v[k] = rv;
            prev_d[k] = rd;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else for (int k = 0; k < 2; k++) model_step(k);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model ready[%0d] t=%0t", k, $time), 32'(rdy[k]), 32'(m_rdy[k]));
                chk($sformatf("model data_valid[%0d] t=%0t", k, $time), 32'(dv[k]), 32'(m_dv[k]));
                chk($sformatf("model data_out[%0d] t=%0t", k, $time), 32'(dout[k]), 32'(m_dout[k]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic acc(input bit c, input bit w, input int a, input logic [7:0] d, input bit cl);
        cs      = c;
        we      = w;
        address = 4'(a);
        data_in = d;
        clear   = cl;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) acc(1'b0, 1'b0, 0, 8'h00, 1'b0);
    endtask

    task automatic count_ready(output int na, output int nb);
        na = -1;
        nb = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (na < 0 && rdy[0]) na = n;
            if (nb < 0 && rdy[1]) nb = n;
        end
        @(negedge clk);
    endtask

    int na, nb;

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset ready a", 32'(rdy[0]), 32'd0);
        chk("reset data_out b", 32'(dout[1]), 32'h0);
        rst = 1'b0;
        count_ready(na, nb);
        chk("clear cycles a", 32'(na), 32'd16);
        chk("clear cycles b", 32'(nb), 32'd12);

        // read-after-write and latency
        acc(1'b1, 1'b1, 3, 8'hA5, 1'b0);
        acc(1'b1, 1'b0, 3, 8'h00, 1'b0);
        chk("raw a valid", 32'(dv[0]), 32'd1);
        chk("raw a data", 32'(dout[0]), 32'hA5);
        chk("raw b early", 32'(dv[1]), 32'd0);
        acc(1'b0, 1'b0, 0, 8'h00, 1'b0);
        chk("raw a pulse width", 32'(dv[0]), 32'd0);
        chk("raw b valid", 32'(dv[1]), 32'd1);
        chk("raw b data", 32'(dout[1]), 32'hA5);
        idle(1);
        chk("raw b pulse width", 32'(dv[1]), 32'd0);

        // out-of-range address for the 12-word instance
        acc(1'b1, 1'b1, 13, 8'h11, 1'b0);
        acc(1'b1, 1'b0, 13, 8'h00, 1'b0);
        chk("addr13 a", 32'(dout[0]), 32'h11);
        idle(1);
        chk("addr13 b data", 32'(dout[1]), 32'h3C);
        chk("addr13 b valid", 32'(dv[1]), 32'd1);

        // back-to-back reads
        for (int i = 0; i < 16; i++) acc(1'b1, 1'b1, i, 8'(i), 1'b0);
        for (int i = 0; i < 16; i++) begin
            acc(1'b1, 1'b0, i, 8'h00, 1'b0);
            chk($sformatf("b2b a data %0d", i), 32'(dout[0]), 32'(i));
            chk($sformatf("b2b a valid %0d", i), 32'(dv[0]), 32'd1);
            if (i >= 1) chk($sformatf("b2b b data %0d", i - 1), 32'(dout[1]),
                            (i - 1 < 12) ? 32'(i - 1) : 32'h3C);
        end
        idle(1);
        chk("b2b b last", 32'(dout[1]), 32'h3C);
        chk("b2b a gap end", 32'(dv[0]), 32'd0);

        // clear with a read on the same edge, write during CLEAR is lost
        for (int i = 0; i < 16; i++) acc(1'b1, 1'b1, i, 8'h5A, 1'b0);
        acc(1'b1, 1'b0, 7, 8'h00, 1'b1);
        chk("clear same-edge read", 32'(dout[0]), 32'h5A);
        chk("clear ready drop", 32'(rdy[0]), 32'd0);
        acc(1'b1, 1'b1, 2, 8'hFF, 1'b0);
        idle(20);
        acc(1'b1, 1'b0, 2, 8'h00, 1'b0);
        chk("write during clear lost", 32'(dout[0]), 32'h00);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            acc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), 8'($urandom), ($urandom_range(0, 31) == 0));
        end
        idle(20);

        // reset with reads in flight
        acc(1'b1, 1'b0, 1, 8'h00, 1'b0);
        acc(1'b1, 1'b0, 2, 8'h00, 1'b0);
        cs = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst ready[%0d]", k), 32'(rdy[k]), 32'd0);
            chk($sformatf("rst data_out[%0d]", k), 32'(dout[k]), 32'h0);
            chk($sformatf("rst valid[%0d]", k), 32'(dv[k]), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst hold valid b", 32'(dv[1]), 32'd0);
        end
        rst = 1'b0;
        count_ready(na, nb);
        chk("reclear cycles a", 32'(na), 32'd16);
        chk("reclear cycles b", 32'(nb), 32'd12);
        idle(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
